alu_nbit_seq: RTL

- Parametrised, registered successor to the 4-bit ALU: WIDTH-bit operands, 3-bit opcode, and an iterative shift-add unsigned multiply.
- Operand/opcode accepted via valid/ready; result held in output registers under valid/ready until consumed.
- Single-entry, one operation in flight; sits between an operand-issue stage and a writeback stage.

---
 rtl/alu_nbit_seq_if.sv | 28 ++
 rtl/alu_nbit_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq_if.sv
// Issue/writeback bundle for alu_nbit_seq: operand valid/ready in, result valid/ready out.
interface alu_nbit_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       s_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] z_hi;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, s_op, out_ready,
    input  in_ready, out_valid, z, z_hi, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, s_op, out_ready,
    output in_ready, out_valid, z, z_hi, cout, ovf, zero
  );
endinterface

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with an iterative shift-add unsigned multiplier.
// One operation in flight; result held under valid/ready until the consumer takes it.
module alu_nbit_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst_n,
  alu_nbit_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand_p0, acc_p0, acc_nxt;
  logic [WIDTH-1:0]   mplier_p0;
  logic [WIDTH-1:0]   z_r, z_hi_r;
  logic               cout_r, ovf_r, zero_r;
  logic               accept, mul_last;
  logic [WIDTH-1:0]   res_lo, bb;
  logic [WIDTH:0]     sum;
  logic               res_c, res_v;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sz);
    return (sa == sb) && (sz != sa);
  endfunction

  assign accept   = bus.in_valid && (state == IDLE);
  assign mul_last = (cnt == CW'(WIDTH - 1));
  assign acc_nxt  = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;

  // Single-cycle datapath, evaluated straight off the operand bus
  always_comb begin
    res_lo = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    bb     = (bus.s_op == OP_SUB) ? ~bus.b : bus.b;
    sum    = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, bus.cin};
    case (bus.s_op)
      OP_ADD, OP_SUB: begin
        res_lo = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
        res_v  = add_ovf(bus.a[WIDTH-1], bb[WIDTH-1], sum[WIDTH-1]);
      end
      OP_AND:  res_lo = bus.a & bus.b;
      OP_OR:   res_lo = bus.a | bus.b;
      OP_XOR:  res_lo = bus.a ^ bus.b;
      OP_SHL:  res_lo = bus.a << bus.b[SHW-1:0];
      OP_SHR:  res_lo = bus.a >> bus.b[SHW-1:0];
      default: res_lo = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (bus.s_op == OP_MUL) ? BUSY : DONE;
      BUSY:    if (mul_last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      z_r    <= '0;
      z_hi_r <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= '0;
      else if (state == BUSY) cnt <= cnt + CW'(1);
      if (accept && bus.s_op != OP_MUL) begin
        z_r    <= res_lo;
        z_hi_r <= '0;
        cout_r <= res_c;
        ovf_r  <= res_v;
        zero_r <= (res_lo == '0);
      end else if (state == BUSY && mul_last) begin
        z_r    <= acc_nxt[WIDTH-1:0];
        z_hi_r <= acc_nxt[2*WIDTH-1:WIDTH];
        cout_r <= 1'b0;
        ovf_r  <= 1'b0;
        zero_r <= (acc_nxt == '0);
      end
    end
  end

  // Multiplier datapath: LSB-first multiplier bit, shifted multiplicand
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p0  <= {{WIDTH{1'b0}}, bus.a};
      mplier_p0 <= bus.b;
      acc_p0    <= '0;
    end else if (state == BUSY) begin
      acc_p0    <= acc_nxt;
      mplier_p0 <= mplier_p0 >> 1;
      mcand_p0  <= mcand_p0 << 1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.z         = z_r;
  assign bus.z_hi      = z_hi_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;

endmodule
